// File: rtl/i2c_pkg.sv
// Shared types and constants for the MPU-6050 I2C sequencer.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_ISSUE,
    ST_INIT_WAIT,
    ST_READY,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_NACK    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam logic [7:0] REG_PWR_MGMT_1   = 8'h6B;
  localparam logic [7:0] REG_CONFIG       = 8'h1A;
  localparam logic [7:0] REG_GYRO_CFG     = 8'h1B;
  localparam logic [7:0] REG_ACCEL_CFG    = 8'h1C;
  localparam logic [7:0] REG_ACCEL_XOUT_H = 8'h3B;

  localparam int INIT_LEN = 4;
  localparam int RD_LEN   = 6;

endpackage

// File: rtl/i2c_init_rom.sv
// Fixed init-write list: index -> (register, data).
module i2c_init_rom
  import i2c_pkg::*;
(
  input  logic [1:0] i_idx,
  output logic [7:0] o_reg,
  output logic [7:0] o_data
);

  // Table lookup of the init entry selected by i_idx.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    o_reg  = REG_PWR_MGMT_1;
    o_data = 8'h00;
    case (i_idx)
      2'd0: begin o_reg = REG_PWR_MGMT_1; o_data = 8'h00; end // wake, internal clock
      2'd1: begin o_reg = REG_CONFIG;     o_data = 8'h03; end // DLPF ~44 Hz
      2'd2: begin o_reg = REG_GYRO_CFG;   o_data = 8'h00; end // +-250 dps
      2'd3: begin o_reg = REG_ACCEL_CFG;  o_data = 8'h08; end // +-4 g
      default: ;
    endcase
  end

endmodule

// File: rtl/i2c_sensor_sequencer.sv
// Drives the single-byte I2C master: init-write list, then periodic
// six-byte accel poll assembled into one 48-bit sample.
module i2c_sensor_sequencer
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h68,
  parameter int         POLL_DIV   = 100000,
  parameter int         TIMEOUT    = 4095,
  parameter int         MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        i2c_en,
  output logic [6:0]  i2c_slave_addr,
  output logic        i2c_rw,
  output logic [7:0]  i2c_reg_addr,
  output logic [7:0]  i2c_wdata,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  input  logic [7:0]  i2c_rdata,
  output logic [47:0] sample,
  output logic        sample_valid,
  output logic        init_done,
  output logic        error,
  output logic [1:0]  err_code
);

  localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_DIV - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
  localparam logic [1:0]    INIT_LAST  = 2'(INIT_LEN - 1);
  localparam logic [2:0]    BYTE_LAST  = 3'(RD_LEN - 1);

  state_t        r_state;
  logic [1:0]    r_idx;
  logic [2:0]    r_byte;
  logic [RW-1:0] r_retry;
  logic [TW-1:0] r_tmo;
  logic [PW-1:0] r_poll;
  logic [47:0]   r_shadow;

  logic          r_en;
  logic [6:0]    r_slave_addr;
  logic          r_rw;
  logic [7:0]    r_reg_addr;
  logic [7:0]    r_wdata;
  logic [47:0]   r_sample;
  logic          r_sample_valid;
  logic          r_init_done;
  logic          r_error;
  logic [1:0]    r_err_code;

  logic [7:0]    w_rom_reg;
  logic [7:0]    w_rom_data;
  logic          w_poll_run;
  logic          w_poll_tick;
  logic          w_timeout;

  i2c_init_rom u_rom (
    .i_idx  (r_idx),
    .o_reg  (w_rom_reg),
    .o_data (w_rom_data)
  );

  assign w_poll_run  = (r_state == ST_READY) || (r_state == ST_RD_ISSUE) ||
                       (r_state == ST_RD_WAIT);
  assign w_poll_tick = (r_poll == POLL_LAST);
  assign w_timeout   = (r_tmo == TMO_LAST);

  // Poll divider: free-runs once initialised, including during bursts;
  // a tick seen outside READY is simply lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_poll <= '0;
    end else if (!w_poll_run || w_poll_tick) begin
      r_poll <= '0;
    end else begin
      r_poll <= r_poll + 1'b1;
    end
  end

  // Sequencer FSM: command issue, response/retry handling, sample assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_byte         <= '0;
      r_retry        <= '0;
      r_tmo          <= '0;
      // NOTE: the shadow is a plain register, not a RAM, so it is reset like
      // everything else and a partial burst never leaks X into sample.
      r_shadow       <= '0;
      r_en           <= 1'b0;
      r_slave_addr   <= '0;
      r_rw           <= 1'b0;
      r_reg_addr     <= '0;
      r_wdata        <= '0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_init_done    <= 1'b0;
      r_error        <= 1'b0;
      r_err_code     <= ERR_NONE;
    end else begin
      // NOTE: non-blocking throughout; later assignments in this block
      // override these one-cycle defaults without ordering hazards.
      r_en           <= 1'b0;
      r_sample_valid <= 1'b0;
      r_slave_addr   <= SLAVE_ADDR;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_idx   <= '0;
            r_retry <= '0;
            r_state <= ST_INIT_ISSUE;
          end
        end
        ST_INIT_ISSUE: begin
          r_en       <= 1'b1;
          r_rw       <= 1'b0;
          r_reg_addr <= w_rom_reg;
          r_wdata    <= w_rom_data;
          r_tmo      <= '0;
          r_state    <= ST_INIT_WAIT;
        end
        ST_RD_ISSUE: begin
          r_en       <= 1'b1;
          r_rw       <= 1'b1;
          r_reg_addr <= REG_ACCEL_XOUT_H + {5'd0, r_byte};
          r_wdata    <= 8'h00;
          r_tmo      <= '0;
          r_state    <= ST_RD_WAIT;
        end
        ST_INIT_WAIT, ST_RD_WAIT: begin
          if (i2c_done && !i2c_nack) begin
            r_retry <= '0;
            if (r_state == ST_INIT_WAIT) begin
              if (r_idx == INIT_LAST) begin
                r_init_done <= 1'b1;
                r_state     <= ST_READY;
              end else begin
                r_idx   <= r_idx + 2'd1;
                r_state <= ST_INIT_ISSUE;
              end
            end else begin
              // Shift in MSB-first: after six bytes byte 0 sits in [47:40].
              r_shadow <= {r_shadow[39:0], i2c_rdata};
              if (r_byte == BYTE_LAST) begin
                r_sample       <= {r_shadow[39:0], i2c_rdata};
                r_sample_valid <= 1'b1;
                r_state        <= ST_READY;
              end else begin
                r_byte  <= r_byte + 3'd1;
                r_state <= ST_RD_ISSUE;
              end
            end
          end else if (i2c_done || w_timeout) begin
            // Done outranks timeout, so a done here is necessarily a NACK.
            if (r_retry < RETRY_MAX) begin
              r_retry <= r_retry + 1'b1;
              r_state <= (r_state == ST_INIT_WAIT) ? ST_INIT_ISSUE : ST_RD_ISSUE;
            end else begin
              r_error    <= 1'b1;
              r_err_code <= i2c_done ? ERR_NACK : ERR_TIMEOUT;
              r_state    <= ST_ERROR;
            end
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        ST_READY: begin
          if (w_poll_tick) begin
            r_byte  <= '0;
            r_retry <= '0;
            r_state <= ST_RD_ISSUE;
          end
        end
        ST_ERROR: begin
          if (start) begin
            r_error     <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_init_done <= 1'b0;
            r_idx       <= '0;
            r_retry     <= '0;
            r_state     <= ST_INIT_ISSUE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign i2c_en         = r_en;
  assign i2c_slave_addr = r_slave_addr;
  assign i2c_rw         = r_rw;
  assign i2c_reg_addr   = r_reg_addr;
  assign i2c_wdata      = r_wdata;
  assign sample         = r_sample;
  assign sample_valid   = r_sample_valid;
  assign init_done      = r_init_done;
  assign error          = r_error;
  assign err_code       = r_err_code;

endmodule

// File: tb/tb_i2c_sensor_sequencer.sv
// Directed bench for i2c_sensor_sequencer with a behavioural I2C master model.
module tb_i2c_sensor_sequencer;

  localparam int POLL_DIV  = 200;
  localparam int TIMEOUT   = 31;
  localparam int MAX_RETRY = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        i2c_en;
  logic [6:0]  i2c_slave_addr;
  logic        i2c_rw;
  logic [7:0]  i2c_reg_addr;
  logic [7:0]  i2c_wdata;
  logic        i2c_done;
  logic        i2c_nack;
  logic [7:0]  i2c_rdata;
  logic [47:0] sample;
  logic        sample_valid;
  logic        init_done;
  logic        error;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  i2c_sensor_sequencer #(
    .SLAVE_ADDR (7'h68),
    .POLL_DIV   (POLL_DIV),
    .TIMEOUT    (TIMEOUT),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .i2c_en         (i2c_en),
    .i2c_slave_addr (i2c_slave_addr),
    .i2c_rw         (i2c_rw),
    .i2c_reg_addr   (i2c_reg_addr),
    .i2c_wdata      (i2c_wdata),
    .i2c_done       (i2c_done),
    .i2c_nack       (i2c_nack),
    .i2c_rdata      (i2c_rdata),
    .sample         (sample),
    .sample_valid   (sample_valid),
    .init_done      (init_done),
    .error          (error),
    .err_code       (err_code)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transaction log and pulse monitors, sampled on the falling edge.
  logic [7:0] log_reg[$];
  logic       log_rw[$];
  logic [7:0] log_wd[$];
  int         log_cyc[$];
  int cyc = 0;
  int sv_count = 0;
  int sv_wide = 0;
  int en_b2b = 0;
  logic prev_en = 1'b0;
  logic prev_sv = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (i2c_en) begin
      log_reg.push_back(i2c_reg_addr);
      log_rw.push_back(i2c_rw);
      log_wd.push_back(i2c_wdata);
      log_cyc.push_back(cyc);
    end
    if (sample_valid) sv_count++;
    if (i2c_en && prev_en) en_b2b++;
    if (sample_valid && prev_sv) sv_wide++;
    prev_en = i2c_en;
    prev_sv = sample_valid;
  end

  // I2C master model: done 20 cycles after each en, optional NACK/no-response.
  logic       never_mode = 1'b0;
  logic [7:0] nack_reg = 8'h00;
  int         nack_left = 0;      // 255 = NACK forever
  logic [7:0] rd_xor = 8'h00;
  logic [7:0] rsp_reg;
  logic       rsp_nack;

  initial begin
    i2c_done  = 1'b0;
    i2c_nack  = 1'b0;
    i2c_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (i2c_en && !never_mode) begin
        rsp_reg  = i2c_reg_addr;
        rsp_nack = 1'b0;
        if (rsp_reg == nack_reg && nack_left > 0) begin
          rsp_nack = 1'b1;
          if (nack_left != 255) nack_left--;
        end
        repeat (20) @(negedge clk);
        i2c_done  = 1'b1;
        i2c_nack  = rsp_nack;
        i2c_rdata = 8'((rsp_reg - 8'h3A) * 8'h11) ^ rd_xor;
        @(negedge clk);
        i2c_done  = 1'b0;
        i2c_nack  = 1'b0;
        i2c_rdata = 8'h00;
      end
    end
  end

  int sv_target = 0;
  int log_target = 0;

  function automatic logic cond(input int which);
    case (which)
      0: return init_done;
      1: return error;
      2: return sv_count >= sv_target;
      default: return log_reg.size() >= log_target;
    endcase
  endfunction

  task automatic wait_until(input int which, input int budget, input string tag);
    int k = 0;
    while (!cond(which) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) check({tag, "_wait_expired"}, 64'd0, 64'd1);
  endtask

  function automatic int count_reg(input logic [7:0] r, input int from);
    int n = 0;
    for (int i = from; i < log_reg.size(); i++) if (log_reg[i] == r) n++;
    return n;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_en"},     64'(i2c_en), 64'd0);
    check({tag, "_saddr"},  64'(i2c_slave_addr), 64'd0);
    check({tag, "_rw"},     64'(i2c_rw), 64'd0);
    check({tag, "_reg"},    64'(i2c_reg_addr), 64'd0);
    check({tag, "_wdata"},  64'(i2c_wdata), 64'd0);
    check({tag, "_sample"}, 64'(sample), 64'd0);
    check({tag, "_sv"},     64'(sample_valid), 64'd0);
    check({tag, "_initd"},  64'(init_done), 64'd0);
    check({tag, "_err"},    64'(error), 64'd0);
    check({tag, "_code"},   64'(err_code), 64'd0);
  endtask

  task automatic clear_log();
    log_reg.delete();
    log_rw.delete();
    log_wd.delete();
    log_cyc.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    never_mode = 1'b0;
    nack_left = 0;
    rd_xor = 8'h00;
    repeat (30) @(negedge clk);
    clear_log();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [7:0] exp_reg[4];
  logic [7:0] exp_wd[4];
  logic [47:0] exp_sample;
  int sv_base;
  int mark;

  initial begin
    exp_reg = '{8'h6B, 8'h1A, 8'h1B, 8'h1C};
    exp_wd  = '{8'h00, 8'h03, 8'h00, 8'h08};
    exp_sample = 48'h112233445566;
    rst_n = 1'b0;
    start = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Normal init and two poll bursts.
    start = 1'b1;
    wait_until(0, 300, "init");
    start = 1'b0;
    check("init_count", 64'(log_reg.size()), 64'd4);
    for (int i = 0; i < 4 && i < log_reg.size(); i++) begin
      check($sformatf("init_reg%0d", i), 64'(log_reg[i]), 64'(exp_reg[i]));
      check($sformatf("init_wd%0d", i),  64'(log_wd[i]),  64'(exp_wd[i]));
      check($sformatf("init_rw%0d", i),  64'(log_rw[i]),  64'd0);
    end
    check("saddr", 64'(i2c_slave_addr), 64'h68);
    check("init_done", 64'(init_done), 64'd1);

    sv_target = 1;
    wait_until(2, 700, "burst1");
    @(negedge clk);
    check("burst1_count", 64'(log_reg.size()), 64'd10);
    for (int i = 0; i < 6 && (4 + i) < log_reg.size(); i++) begin
      check($sformatf("rd_reg%0d", i), 64'(log_reg[4 + i]), 64'(8'h3B + 8'(i)));
      check($sformatf("rd_rw%0d", i),  64'(log_rw[4 + i]),  64'd1);
      check($sformatf("rd_wd%0d", i),  64'(log_wd[4 + i]),  64'd0);
    end
    check("sample1", 64'(sample), 64'(exp_sample));
    check("sv_count1", 64'(sv_count), 64'd1);
    sv_target = 2;
    wait_until(2, 400, "burst2");
    if (log_cyc.size() > 10)
      check("burst_spacing", 64'(log_cyc[10] - log_cyc[4]), 64'(POLL_DIV));
    else
      check("burst_spacing_missing", 64'(log_cyc.size()), 64'd11);
    check("sample2", 64'(sample), 64'(exp_sample));
    check("sv_width", 64'(sv_wide), 64'd0);

    // NACK twice on init entry 2, then ACK.
    do_reset();
    nack_reg  = 8'h1B;
    nack_left = 2;
    start = 1'b1;
    wait_until(0, 400, "nack_init");
    start = 1'b0;
    check("nack_1b_issues", 64'(count_reg(8'h1B, 0)), 64'd3);
    check("nack_total", 64'(log_reg.size()), 64'd6);
    check("nack_no_err", 64'(error), 64'd0);
    check("nack_initd", 64'(init_done), 64'd1);

    // No response at all: four issues of 6B spaced TIMEOUT+2, then timeout error.
    do_reset();
    never_mode = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_until(1, 300, "tmo_err");
    check("tmo_issues", 64'(log_reg.size()), 64'd4);
    check("tmo_all_6b", 64'(count_reg(8'h6B, 0)), 64'd4);
    for (int i = 1; i < 4 && i < log_cyc.size(); i++)
      check($sformatf("tmo_spacing%0d", i), 64'(log_cyc[i] - log_cyc[i - 1]), 64'(TIMEOUT + 2));
    check("tmo_code", 64'(err_code), 64'd2);
    repeat (50) @(negedge clk);
    check("tmo_en_quiet", 64'(log_reg.size()), 64'd4);
    check("tmo_err_sticky", 64'(error), 64'd1);
    never_mode = 1'b0;
    start = 1'b1;
    log_target = 5;
    wait_until(3, 10, "tmo_restart");
    start = 1'b0;
    if (log_reg.size() > 4) check("restart_reg", 64'(log_reg[4]), 64'h6B);
    check("restart_err_clr", 64'(error), 64'd0);
    check("restart_code_clr", 64'(err_code), 64'd0);
    check("restart_initd_clr", 64'(init_done), 64'd0);
    wait_until(0, 300, "restart_init");

    // Persistent NACK on read byte 3: error, old sample kept, no valid.
    sv_target = sv_count + 1;
    wait_until(2, 700, "pre_nack_burst");
    @(negedge clk);
    check("pre_nack_sample", 64'(sample), 64'(exp_sample));
    sv_base = sv_count;
    mark = log_reg.size();
    nack_reg  = 8'h3E;
    nack_left = 255;
    rd_xor    = 8'hA0;
    wait_until(1, 900, "rd_nack_err");
    check("rd_nack_code", 64'(err_code), 64'd1);
    check("rd_nack_issues", 64'(count_reg(8'h3E, mark)), 64'd4);
    check("rd_nack_sample", 64'(sample), 64'(exp_sample));
    check("rd_nack_no_sv", 64'(sv_count), 64'(sv_base));

    // Reset while waiting on read byte 4.
    nack_left = 0;
    rd_xor    = 8'h00;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_until(0, 300, "rst_test_init");
    mark = log_reg.size();
    log_target = mark + 5;
    wait_until(3, 700, "byte4_issue");
    if (log_reg.size() > mark + 4) check("byte4_reg", 64'(log_reg[mark + 4]), 64'h3F);
    sv_base = sv_count;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("midrst");
    repeat (40) @(negedge clk);
    check("midrst_no_sv", 64'(sv_count), 64'(sv_base));
    clear_log();
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    log_target = 1;
    wait_until(3, 10, "rerun_first");
    start = 1'b0;
    if (log_reg.size() > 0) check("rerun_reg0", 64'(log_reg[0]), 64'h6B);
    wait_until(0, 300, "rerun_init");
    check("rerun_count", 64'(log_reg.size()), 64'd4);
    if (log_reg.size() > 3) check("rerun_reg3", 64'(log_reg[3]), 64'h1C);

    check("no_b2b_en", 64'(en_b2b), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
